// File: rtl/dcache.sv
`default_nettype none
// ============================================================================
// Module   : dcache
// Purpose  : direct-mapped, write-back, write-allocate data cache with a
//            128-bit line memory port; DCACHE_STATS_EN adds hit/miss counters
// Revision : 1.0
// ============================================================================
module dcache #(
   parameter int LINES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [31:0]  addr,
   input  logic [31:0]  wdata,
   input  logic         load,
   input  logic         store,
   input  logic         byte_en,
   output logic [31:0]  rdata,
   output logic         dhit,
   output logic         mem_req,
   output logic         mem_we,
   output logic [31:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]  hit_count,
   output logic [31:0]  miss_count
`endif
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 28 - IDX_W;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WB     = 2'd1,
      S_REFILL = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [LINES-1:0]   valid_q, valid_d;
   logic [LINES-1:0]   dirty_q, dirty_d;
   logic [127:0]       data_q [LINES];
   logic [127:0]       data_d [LINES];
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [TAG_W-1:0]   tag_d  [LINES];

   logic [IDX_W-1:0]   idx;
   logic [TAG_W-1:0]   tag;
   logic [6:0]         word_base;
   logic               access;
   logic               hit;
   logic [127:0]       cur_line;
   logic [31:0]        word_new;
   logic [127:0]       store_line;

   assign idx       = addr[IDX_W+3:4];
   assign tag       = addr[31:IDX_W+4];
   assign word_base = {addr[3:2], 5'd0};
   assign access    = load | store;
   assign hit       = valid_q[idx] && (tag_q[idx] == tag);
   assign cur_line  = data_q[idx];
   assign rdata     = cur_line[word_base +: 32];
   assign dhit      = !access || ((state_q == S_IDLE) && hit);

   // Big-endian byte lanes: offset 0 is the most significant byte of the word.
   always_comb begin
      word_new = wdata;
      if (byte_en) begin
         word_new = rdata;
         case (addr[1:0])
            2'd0:    word_new[31:24] = wdata[7:0];
            2'd1:    word_new[23:16] = wdata[7:0];
            2'd2:    word_new[15:8]  = wdata[7:0];
            default: word_new[7:0]   = wdata[7:0];
         endcase
      end
      store_line = cur_line;
      store_line[word_base +: 32] = word_new;
   end

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      dirty_d   = dirty_q;
      data_d    = data_q;
      tag_d     = tag_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 128'd0;
      case (state_q)
         S_IDLE: begin
            if (access) begin
               if (hit) begin
                  if (store) begin
                     data_d[idx]  = store_line;
                     dirty_d[idx] = 1'b1;
                  end
               end else if (valid_q[idx] && dirty_q[idx]) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_REFILL;
               end
            end
         end
         S_WB: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {tag_q[idx], idx, 4'b0000};
            mem_wdata = data_q[idx];
            if (mem_ready) begin
               state_d = S_REFILL;
            end
         end
         S_REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {addr[31:4], 4'b0000};
            if (mem_ready) begin
               data_d[idx]  = mem_rdata;
               tag_d[idx]   = tag;
               valid_d[idx] = 1'b1;
               dirty_d[idx] = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Line storage carries no reset; valid_q guards every use.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      tag_q  <= tag_d;
   end

`ifdef DCACHE_STATS_EN
   logic        after_miss_q, after_miss_d;
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;

   // The hit that completes a serviced miss is not counted as a hit.
   always_comb begin
      after_miss_d = after_miss_q;
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if ((state_q == S_IDLE) && access) begin
         if (!hit) begin
            miss_count_d = miss_count_q + 32'd1;
            after_miss_d = 1'b1;
         end else begin
            if (!after_miss_q) begin
               hit_count_d = hit_count_q + 32'd1;
            end
            after_miss_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         after_miss_q <= 1'b0;
         hit_count_q  <= 32'd0;
         miss_count_q <= 32'd0;
      end else begin
         after_miss_q <= after_miss_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache
// Purpose  : directed self-checking bench for dcache with a latency-3 memory
// Revision : 1.0
// ============================================================================
module tb_dcache;

   localparam int LAT = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [31:0]  addr = '0;
   logic [31:0]  wdata = '0;
   logic         load = 1'b0;
   logic         store = 1'b0;
   logic         byte_en = 1'b0;
   logic [31:0]  rdata;
   logic         dhit;
   logic         mem_req;
   logic         mem_we;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata = '0;
   logic         mem_ready = 1'b0;
`ifdef DCACHE_STATS_EN
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;
`endif

   dcache #(.LINES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .wdata     (wdata),
      .load      (load),
      .store     (store),
      .byte_en   (byte_en),
      .rdata     (rdata),
      .dhit      (dhit),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count (hit_count),
      .miss_count(miss_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory model: responds LAT cycles into each request.
   logic [127:0] mem_model [logic [31:0]];
   int           rd_cnt = 0;
   int           wb_cnt = 0;
   logic [31:0]  last_rd_addr = '0;
   logic [31:0]  last_wb_addr = '0;
   logic [127:0] last_wb_data = '0;

   initial begin
      int cnt;
      cnt = 0;
      mem_model[32'h100] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      forever begin
         @(negedge clk);
         mem_ready = 1'b0;
         if (mem_req && !reset) begin
            cnt++;
            if (cnt == LAT) begin
               cnt = 0;
               mem_ready = 1'b1;
               if (mem_we) begin
                  wb_cnt++;
                  last_wb_addr = mem_addr;
                  last_wb_data = mem_wdata;
                  mem_model[mem_addr] = mem_wdata;
               end else begin
                  rd_cnt++;
                  last_rd_addr = mem_addr;
                  mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : {4{mem_addr}};
               end
            end
         end else begin
            cnt = 0;
         end
      end
   end

   task automatic access(input logic ld, input logic st, input logic be,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int stalls, output logic [31:0] rd);
      @(negedge clk);
      addr = a; wdata = wd; load = ld; store = st; byte_en = be;
      stalls = 0;
      #2;
      while (!dhit && stalls < 100) begin
         stalls++;
         @(negedge clk);
         #2;
      end
      check("access_done", {127'd0, dhit}, 128'd1);
      rd = rdata;
      @(posedge clk);
      #1;
      load = 1'b0; store = 1'b0; byte_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          st;
      logic [31:0] rd;

      #3;
      check("rst_dhit", {127'd0, dhit}, 128'd1);
      check("rst_mem_req", {127'd0, mem_req}, 128'd0);
      check("rst_mem_we", {127'd0, mem_we}, 128'd0);
      check("rst_mem_addr", {96'd0, mem_addr}, 128'd0);
      check("rst_mem_wdata", mem_wdata, 128'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Clean miss then hit
      access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, st, rd);
      check("miss1_stalls", 128'(st), 128'd4);
      check("miss1_rd_cnt", 128'(rd_cnt), 128'd1);
      check("miss1_rd_addr", {96'd0, last_rd_addr}, 128'h100);
      check("miss1_rdata", {96'd0, rd}, 128'hCCDDEEFF);

      // Word store hit, then load it back
      access(1'b0, 1'b1, 1'b0, 32'h104, 32'hDEADBEEF, st, rd);
      check("st_word_stalls", 128'(st), 128'd0);
      access(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, st, rd);
      check("ld104_stalls", 128'(st), 128'd0);
      check("ld104_rdata", {96'd0, rd}, 128'hDEADBEEF);
      check("ld104_no_req", 128'(rd_cnt), 128'd1);

      // Byte store into lane 1 of word 0
      access(1'b0, 1'b1, 1'b1, 32'h101, 32'h000000A5, st, rd);
      check("st_byte_stalls", 128'(st), 128'd0);
      access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, st, rd);
      check("ld100_rdata", {96'd0, rd}, 128'hCCA5EEFF);

      // Conflict miss with dirty victim: write-back then refill
      access(1'b1, 1'b0, 1'b0, 32'h140, 32'h0, st, rd);
      check("dirty_stalls", 128'(st), 128'd7);
      check("dirty_wb_cnt", 128'(wb_cnt), 128'd1);
      check("dirty_wb_addr", {96'd0, last_wb_addr}, 128'h100);
      check("dirty_wb_data", last_wb_data, 128'h00112233_44556677_DEADBEEF_CCA5EEFF);
      check("dirty_rd_addr", {96'd0, last_rd_addr}, 128'h140);
      check("dirty_rdata", {96'd0, rd}, 128'h00000140);
`ifdef DCACHE_STATS_EN
      check("stats_miss", {96'd0, miss_count}, 128'd2);
      check("stats_hit", {96'd0, hit_count}, 128'd4);
`endif

      // Other words of the refilled line, via a hit
      access(1'b1, 1'b0, 1'b0, 32'h14C, 32'h0, st, rd);
      check("ld14c_stalls", 128'(st), 128'd0);
      check("ld14c_rdata", {96'd0, rd}, 128'h00000140);

      // Reset asserted while a refill is outstanding
      @(negedge clk);
      addr = 32'h120; load = 1'b1;
      @(negedge clk);
      #2;
      check("refill_req", {127'd0, mem_req}, 128'd1);
      check("refill_addr", {96'd0, mem_addr}, 128'h120);
      reset = 1'b1;
      #1;
      check("async_req_drop", {127'd0, mem_req}, 128'd0);
      check("async_addr_zero", {96'd0, mem_addr}, 128'd0);
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check("post_rst_rd_cnt", 128'(rd_cnt), 128'd2);

      // Valid cleared: clean miss re-fetches the written-back line
      access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, st, rd);
      check("post_rst_stalls", 128'(st), 128'd4);
      check("post_rst_wb_cnt", 128'(wb_cnt), 128'd1);
      check("post_rst_rdata", {96'd0, rd}, 128'hCCA5EEFF);
      access(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, st, rd);
      check("post_rst_ld104", {96'd0, rd}, 128'hDEADBEEF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
